// File: rtl/jk_ff_bank.sv
// ----------------------------------------------------------------------------
// jk_ff_bank
//   Bank of WIDTH flip-flops sharing one clock, enable and mode select.
//   Each channel behaves as a JK, T, D or SR flip-flop depending on i_mode.
//   Alongside the state the bank keeps a saturating count of individual bit
//   transitions, a one-cycle change strobe and a sticky illegal-SR flag.
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         asynchronous active-low reset
//   i_en          update enable; 0 holds the bank
//   i_mode        00 JK, 01 T, 10 D, 11 SR (all channels)
//   i_j           per-channel J / T / D / S input
//   i_k           per-channel K / R input (unused in T and D)
//   i_clr_err     synchronous clear of o_sr_err (a new set wins)
//   o_y           flip-flop state
//   o_y_n         registered complement of o_y
//   o_changed     high for one cycle after any bit of o_y changed
//   o_toggle_cnt  saturating count of bit transitions
//   o_sr_err      sticky flag: S=R=1 seen in SR mode
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ----------------------------------------------------------------------------
module jk_ff_bank #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_j,
   input  logic [WIDTH-1:0] i_k,
   input  logic             i_clr_err,
   output logic [WIDTH-1:0] o_y,
   output logic [WIDTH-1:0] o_y_n,
   output logic             o_changed,
   output logic [CNT_W-1:0] o_toggle_cnt,
   output logic             o_sr_err
);

   typedef enum logic [1:0] {
      MODE_JK = 2'b00,
      MODE_T  = 2'b01,
      MODE_D  = 2'b10,
      MODE_SR = 2'b11
   } mode_t;

   localparam int PC_W = $clog2(WIDTH + 1);
   // Sum is at least one bit wider than the counter so overflow is visible;
   // widened further if the popcount alone would not fit.
   localparam int SUM_W = (CNT_W + 1 > PC_W + 1) ? CNT_W + 1 : PC_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_y_n;
   logic             r_changed;
   logic [CNT_W-1:0] r_toggle_cnt;
   logic             r_sr_err;

   logic [WIDTH-1:0] w_y_next;
   logic [WIDTH-1:0] w_diff;
   logic [PC_W-1:0]  w_popcnt;
   logic [SUM_W-1:0] w_sum;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_sr_illegal;
   mode_t            w_mode;

   assign w_mode = mode_t'(i_mode);

   // Per-channel next state; an illegal SR pair simply holds that channel.
   always_comb begin
      w_y_next = r_y;
      if (i_en) begin
         for (int i = 0; i < WIDTH; i++) begin
            unique case (w_mode)
               MODE_JK: begin
                  unique case ({i_j[i], i_k[i]})
                     2'b00:   w_y_next[i] = r_y[i];
                     2'b01:   w_y_next[i] = 1'b0;
                     2'b10:   w_y_next[i] = 1'b1;
                     default: w_y_next[i] = ~r_y[i];
                  endcase
               end
               MODE_T:  w_y_next[i] = i_j[i] ? ~r_y[i] : r_y[i];
               MODE_D:  w_y_next[i] = i_j[i];
               default: begin
                  unique case ({i_j[i], i_k[i]})
                     2'b01:   w_y_next[i] = 1'b0;
                     2'b10:   w_y_next[i] = 1'b1;
                     default: w_y_next[i] = r_y[i];
                  endcase
               end
            endcase
         end
      end
   end

   assign w_diff = w_y_next ^ r_y;

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_popcnt = w_popcnt + PC_W'(w_diff[i]);
      end
   end

   assign w_sum        = SUM_W'(r_toggle_cnt) + SUM_W'(w_popcnt);
   assign w_cnt_next   = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
   assign w_sr_illegal = i_en && (w_mode == MODE_SR) && (|(i_j & i_k));

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_y          <= '0;
         r_y_n        <= '1;
         r_changed    <= 1'b0;
         r_toggle_cnt <= '0;
         r_sr_err     <= 1'b0;
      end else begin
         r_y          <= w_y_next;
         r_y_n        <= ~w_y_next;
         r_changed    <= i_en && (|w_diff);
         r_toggle_cnt <= w_cnt_next;
         // Set has priority over a simultaneous clear.
         if (w_sr_illegal) begin
            r_sr_err <= 1'b1;
         end else if (i_clr_err) begin
            r_sr_err <= 1'b0;
         end
      end
   end

   assign o_y          = r_y;
   assign o_y_n        = r_y_n;
   assign o_changed    = r_changed;
   assign o_toggle_cnt = r_toggle_cnt;
   assign o_sr_err     = r_sr_err;

endmodule

// File: tb/tb_jk_ff_bank.sv
// ----------------------------------------------------------------------------
// tb_jk_ff_bank
//   Self-checking bench for jk_ff_bank. Two instances share all inputs: one
//   with an 8-bit counter and one with a 4-bit counter for saturation.
//   Inputs change on the falling edge; each update's expected outputs are
//   pushed to exp_q when driven and popped/compared on the following falling
//   edge, after the rising edge that consumes them.
// ----------------------------------------------------------------------------
module tb_jk_ff_bank;

  // --------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = 8'h00;
  logic [7:0] k = 8'h00;
  logic       clr = 1'b0;

  logic [7:0] y8, yn8, cnt8;
  logic       ch8, err8;
  logic [7:0] y4, yn4;
  logic [3:0] cnt4;
  logic       ch4, err4;

  jk_ff_bank #(.WIDTH(8), .CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_j(j), .i_k(k),
    .i_clr_err(clr), .o_y(y8), .o_y_n(yn8), .o_changed(ch8),
    .o_toggle_cnt(cnt8), .o_sr_err(err8)
  );

  jk_ff_bank #(.WIDTH(8), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_j(j), .i_k(k),
    .i_clr_err(clr), .o_y(y4), .o_y_n(yn4), .o_changed(ch4),
    .o_toggle_cnt(cnt4), .o_sr_err(err4)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;

  // packed expectation: {y, y_n, changed, cnt8, cnt4, sr_err}
  logic [29:0] exp_q[$];

  logic [7:0] m_y   = 8'h00;
  logic       m_ch  = 1'b0;
  logic [7:0] m_c8  = 8'h00;
  logic [3:0] m_c4  = 4'h0;
  logic       m_err = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 8'h00; m_ch = 1'b0; m_c8 = 8'h00; m_c4 = 4'h0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [29:0] e);
    check_val({tag, ".y"},    {24'h0, y8},   {24'h0, e[29:22]});
    check_val({tag, ".y_n"},  {24'h0, yn8},  {24'h0, e[21:14]});
    check_val({tag, ".chg"},  {31'h0, ch8},  {31'h0, e[13]});
    check_val({tag, ".cnt8"}, {24'h0, cnt8}, {24'h0, e[12:5]});
    check_val({tag, ".cnt4"}, {28'h0, cnt4}, {28'h0, e[4:1]});
    check_val({tag, ".err"},  {31'h0, err8}, {31'h0, e[0]});
    check_val({tag, ".y4"},   {24'h0, y4},   {24'h0, e[29:22]});
  endtask

  // Behavioural model of one clock update, applied to the current inputs.
  task automatic model_step();
    logic [7:0] nxt;
    int pc, s;
    nxt = m_y;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        case (mode)
          2'b00: nxt[i] = (j[i] && k[i]) ? ~m_y[i] : (j[i] ? 1'b1 : (k[i] ? 1'b0 : m_y[i]));
          2'b01: nxt[i] = j[i] ? ~m_y[i] : m_y[i];
          2'b10: nxt[i] = j[i];
          default: nxt[i] = (j[i] && !k[i]) ? 1'b1 : ((!j[i] && k[i]) ? 1'b0 : m_y[i]);
        endcase
      end
    end
    pc = 0;
    for (int i = 0; i < 8; i++) pc += (nxt[i] != m_y[i]) ? 1 : 0;
    m_ch = en && (pc != 0);
    s = int'(m_c8) + pc;
    m_c8 = (s > 255) ? 8'hFF : 8'(s);
    s = int'(m_c4) + pc;
    m_c4 = (s > 15) ? 4'hF : 4'(s);
    if (en && mode == 2'b11 && ((j & k) != 8'h00)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_y = nxt;
  endtask

  // ------------------------------------------------------------ driver tasks
  // Called on a falling edge: drive, push expectation, clock, pop and compare.
  task automatic step(input string tag, input logic e, input logic [1:0] md,
                      input logic [7:0] jj, input logic [7:0] kk, input logic c);
    logic [29:0] e_v;
    en = e; mode = md; j = jj; k = kk; clr = c;
    model_step();
    exp_q.push_back({m_y, ~m_y, m_ch, m_c8, m_c4, m_err});
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e_v = exp_q.pop_front();
      check_all(tag, e_v);
    end
  endtask

  // Assert reset just after a falling edge, check outputs while held, release
  // on a later falling edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all({tag, ".imm"}, {m_y, ~m_y, m_ch, m_c8, m_c4, m_err});
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".held"}, {m_y, ~m_y, m_ch, m_c8, m_c4, m_err});
    en = 1'b0;
    rst = 1'b1;
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    @(negedge clk);
    do_reset("rst0");

    // load A5, then reset mid-cycle with an enabled update in flight
    step("loadA5", 1'b1, 2'b10, 8'hA5, 8'h00, 1'b0);
    en = 1'b1; mode = 2'b10; j = 8'h5A; k = 8'h00;
    do_reset("rst_mid");
    for (int n = 0; n < 3; n++) step("hold", 1'b0, 2'b00, 8'hFF, 8'h00, 1'b0);

    // JK mode
    step("jk_set",    1'b1, 2'b00, 8'hF0, 8'h0F, 1'b0);   // y=F0 cnt=4
    step("jk_tog",    1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);   // y=0F cnt=12
    step("jk_hold",   1'b1, 2'b00, 8'h00, 8'h00, 1'b0);   // chg=0
    // T and D modes
    step("t_tog",     1'b1, 2'b01, 8'h0F, 8'hFF, 1'b0);   // y=00 cnt=16
    step("d_load",    1'b1, 2'b10, 8'h3C, 8'hC3, 1'b0);   // y=3C
    step("d_zero",    1'b1, 2'b10, 8'h00, 8'hFF, 1'b0);   // y=00
    // SR mode
    step("sr_ill",    1'b1, 2'b11, 8'h81, 8'h01, 1'b0);   // y=80 err=1
    step("sr_setwin", 1'b1, 2'b11, 8'h01, 8'h01, 1'b1);   // err stays 1
    step("sr_clr",    1'b1, 2'b11, 8'h00, 8'h00, 1'b1);   // err=0
    step("sr_clrd",   1'b1, 2'b11, 8'h0F, 8'h30, 1'b0);   // y=8F
    // disable gating
    step("dis_sr",    1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0);
    step("dis_d",     1'b0, 2'b10, 8'h00, 8'h00, 1'b0);

    // random mix
    for (int n = 0; n < 40; n++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    // saturation of the 4-bit counter from reset
    do_reset("rst_sat");
    step("sat1", 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);        // cnt4=8
    step("sat2", 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);        // cnt4=15
    step("sat3", 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);        // cnt4=15

    // explicit spot checks of the saturating counters against constants
    check_val("sat_c4_const", {28'h0, cnt4}, 32'd15);
    check_val("sat_c8_const", {24'h0, cnt8}, 32'd24);

    // ------------------------------------------------------------ final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
